hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Upstream neighbour of the NOP issuer in the 5-stage MIPS pipeline.
- Decides every cycle whether the D-stage instruction must stall.
- Drives the PC enable, the IF/ID register enable, and the `enable` input of the NOP issuer that feeds D/E.
- Contains the multiply/divide busy sequencer, so stalls caused by the multi-cycle MD unit are generated here.

Parameters:
- REG_ADDR_W, 5, GPR address width.
- MULT_CYCLES, 5, busy cycles after a mult/multu start (≥1).
- DIV_CYCLES, 10, busy cycles after a div/divu start (≥1).
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- d_rs_addr  in  REG_ADDR_W  D-stage rs.
- d_rt_addr  in  REG_ADDR_W  D-stage rt.
- d_rs_tuse  in  2  cycles until rs is needed; 3 = unused.
- d_rt_tuse  in  2  cycles until rt is needed; 3 = unused.
- d_uses_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_dst_addr  in  REG_ADDR_W  E-stage destination; 0 = no write.
- e_tnew  in  2  E-stage cycles until result is forwardable.
- m_dst_addr  in  REG_ADDR_W  M-stage destination; 0 = no write.
- m_tnew  in  2  M-stage tnew.
- md_start  in  1  E-stage mult/div starts this cycle.
- md_is_div  in  1  qualifies md_start: 1 = div, 0 = mult.
- pc_enable  out  1  PC update enable.
- ifid_enable  out  1  IF/ID register enable.
- nop_enable  out  1  to NOP issuer: 1 = pass instruction, 0 = insert NOP into D/E.
- md_busy  out  1  registered; MD unit occupied.

Behaviour:
- rs_hz = (d_rs_addr≠0) & ((d_rs_addr==e_dst_addr & e_tnew>d_rs_tuse) | (d_rs_addr==m_dst_addr & m_tnew>d_rs_tuse)). rt_hz is identical with the rt inputs.
- Unsigned 2-bit compares. tuse=3 never stalls, because tnew ≤2 is the legal range.
- md_hz = d_uses_md & (md_busy | md_start).
- stall = rs_hz | rt_hz | md_hz, all combinational, zero latency.
- pc_enable = ifid_enable = nop_enable = ~stall.
- MD sequencer, states IDLE and BUSY, with counter cnt[CNT_W]:
  - IDLE, md_start=1: cnt ← md_is_div ? DIV_CYCLES : MULT_CYCLES; go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, go to IDLE and cnt ← 0.
  - md_busy = (state==BUSY), registered.
- Timing: md_start at edge window t gives md_busy high for exactly N cycles (t+1 .. t+N). A D-stage MD instruction held from t is released at t+N+1.
- md_start while BUSY is ignored: no reload, no extension. This cannot occur legally, because D is stalled.
- md_start with md_is_div=X while IDLE is undefined. The bench drives only known values.
- Reset: asynchronous on rst_n low. State ← IDLE, cnt ← 0, md_busy ← 0.
- Reset asserted mid-BUSY aborts the operation immediately. After release, the first md_start starts a fresh count.
- Combinational outputs during reset follow the inputs with md_busy=0.
- Same register present in both E and M: the stall is the OR of both terms; there is no priority.

Optional Feature:
- Macro: HAZARD_STALL_PERF_EN.
- When defined:
  - Adds outputs stall_cycles[31:0] and md_stall_cycles[31:0].
  - stall_cycles increments on every clock with stall=1; md_stall_cycles increments on every clock with md_hz=1.
  - Both are cleared by rst_n and wrap at 2^32.
- When undefined: the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_pkg):
  - TUSE_NONE=2'd3.
  - Tnew/Tuse typedefs (2-bit).
  - REG_ZERO.
  - MD state enum {MD_IDLE, MD_BUSY}.
- One natural sub-module: md_busy_sequencer, containing the state, counter and md_busy.
- The hazard compare stays inline.

Test Plan:
1. Load-use: E holds lw to $8 with e_tnew=2; D is addu with rs=$8, rs_tuse=1 → stall=1, all three enables 0. Next cycle with e_tnew=0 and m_tnew=1 → enables 1.
2. $0 immunity: d_rs_addr=0, e_dst_addr=0, e_tnew=2, rs_tuse=0 → no stall.
3. Mult sequencing: md_start=1, md_is_div=0 at cycle 10 → md_busy high cycles 11-15, low at 16. With d_uses_md=1 throughout, enables are 0 at cycles 10-15 and 1 at 16.
4. Div sequencing: md_is_div=1 → md_busy high for exactly 10 cycles. A second md_start during BUSY → the count is not extended.
5. Reset mid-BUSY: assert rst_n=0 at busy cycle 3 → md_busy drops asynchronously. After release, a new mult gives a full 5-cycle busy window.
6. With HAZARD_STALL_PERF_EN: scenario 3 leaves md_stall_cycles=6 and stall_cycles=6.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard timing (Tnew/Tuse) encodings and MD sequencer states.
// Pure declarations, no logic, so no latency.
// Not applicable: there is no handshake here.
package pipeline_pkg;

  // Tnew/Tuse are 2-bit cycle distances. Legal Tnew never exceeds 2.
  // A Tuse of 3 therefore marks "operand unused" and can never stall.
  typedef logic [1:0] tnew_t;
  typedef logic [1:0] tuse_t;

  localparam tuse_t      TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_busy_sequencer.sv
// Multiply/divide occupancy tracker: holds md_busy for a fixed number of cycles after each start.
// md_busy rises one cycle after md_start and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
// md_start is ignored while busy; a start cannot legally arrive then because D is stalled.
module md_busy_sequencer
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on start from IDLE, count down while BUSY, leave after the last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = MD_IDLE;
      end
    endcase
  end

  // Busy is the state flop itself, so it is glitch-free and registered.
  assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// D-stage stall decision: data hazards against E/M producers plus MD-unit occupancy; drives PC, IF/ID and NOP-issuer enables.
// Stall is combinational (zero latency); md_busy is registered.
// Stalling freezes PC and IF/ID and makes the NOP issuer insert a bubble into D/E.
// Optional build macro HAZARD_STALL_PERF_EN adds stall_cycles/md_stall_cycles event counters.
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] d_rs_addr,
  input  logic [REG_ADDR_W-1:0] d_rt_addr,
  input  logic [1:0]            d_rs_tuse,
  input  logic [1:0]            d_rt_tuse,
  input  logic                  d_uses_md,
  input  logic [REG_ADDR_W-1:0] e_dst_addr,
  input  logic [1:0]            e_tnew,
  input  logic [REG_ADDR_W-1:0] m_dst_addr,
  input  logic [1:0]            m_tnew,
  input  logic                  md_start,
  input  logic                  md_is_div,
`ifdef HAZARD_STALL_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           md_stall_cycles,
`endif
  output logic                  pc_enable,
  output logic                  ifid_enable,
  output logic                  nop_enable,
  output logic                  md_busy
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

  logic rs_hz, rt_hz, md_hz, stall;

  md_busy_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy)
  );

  // A source stalls when a producer in E or M will not have its result ready by the time D needs it.
  // $0 is never a real dependency; E and M terms are simply ORed (no priority between stages).
  always_comb begin
    rs_hz = (d_rs_addr != ZERO_ADDR) &
            (((d_rs_addr == e_dst_addr) & (e_tnew > d_rs_tuse)) |
             ((d_rs_addr == m_dst_addr) & (m_tnew > d_rs_tuse)));
    rt_hz = (d_rt_addr != ZERO_ADDR) &
            (((d_rt_addr == e_dst_addr) & (e_tnew > d_rt_tuse)) |
             ((d_rt_addr == m_dst_addr) & (m_tnew > d_rt_tuse)));
    // md_start counts too: the op entering E this cycle occupies the unit from the next cycle.
    md_hz = d_uses_md & (md_busy | md_start);
    stall = rs_hz | rt_hz | md_hz;
  end

  assign pc_enable   = ~stall;
  assign ifid_enable = ~stall;
  assign nop_enable  = ~stall;

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles_q, md_stall_cycles_q;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q    <= '0;
      md_stall_cycles_q <= '0;
    end else begin
      if (stall) stall_cycles_q    <= stall_cycles_q + 32'd1;
      if (md_hz) md_stall_cycles_q <= md_stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: data hazards, $0 immunity, mult/div busy windows, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Counter checks are included only when HAZARD_STALL_PERF_EN is defined.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_rs_addr, d_rt_addr, e_dst_addr, m_dst_addr;
  logic [1:0] d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic       d_uses_md, md_start, md_is_div;
  logic       pc_enable, ifid_enable, nop_enable, md_busy;
`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .REG_ADDR_W  (5),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_rs_addr   (d_rs_addr),
    .d_rt_addr   (d_rt_addr),
    .d_rs_tuse   (d_rs_tuse),
    .d_rt_tuse   (d_rt_tuse),
    .d_uses_md   (d_uses_md),
    .e_dst_addr  (e_dst_addr),
    .e_tnew      (e_tnew),
    .m_dst_addr  (m_dst_addr),
    .m_tnew      (m_tnew),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
`ifdef HAZARD_STALL_PERF_EN
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles),
`endif
    .pc_enable   (pc_enable),
    .ifid_enable (ifid_enable),
    .nop_enable  (nop_enable),
    .md_busy     (md_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_en(input string tag, input logic exp);
    check({tag, ".pc"},   {31'd0, pc_enable},   {31'd0, exp});
    check({tag, ".ifid"}, {31'd0, ifid_enable}, {31'd0, exp});
    check({tag, ".nop"},  {31'd0, nop_enable},  {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    d_uses_md = 1'b0; e_dst_addr = 5'd0; e_tnew = 2'd0;
    m_dst_addr = 5'd0; m_tnew = 2'd0; md_start = 1'b0; md_is_div = 1'b0;
  endtask

  // Applies one hazard vector and checks the combinational enables.
  task automatic hz_vec(input string tag,
                        input logic [4:0] rs, input logic [1:0] rs_tuse,
                        input logic [4:0] rt, input logic [1:0] rt_tuse,
                        input logic [4:0] e_dst, input logic [1:0] e_tn,
                        input logic [4:0] m_dst, input logic [1:0] m_tn,
                        input logic exp_en);
    d_rs_addr = rs; d_rs_tuse = rs_tuse; d_rt_addr = rt; d_rt_tuse = rt_tuse;
    e_dst_addr = e_dst; e_tnew = e_tn; m_dst_addr = m_dst; m_tnew = m_tn;
    @(negedge clk);
    check_en(tag, exp_en);
    step();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("reset.md_busy", {31'd0, md_busy}, 32'd0);
    check_en("reset", 1'b1);
    rst_n = 1'b1;
    step();
`ifdef HAZARD_STALL_PERF_EN
    check("reset.stall_cycles", stall_cycles, 32'd0);
    check("reset.md_stall_cycles", md_stall_cycles, 32'd0);
`endif

    // Mult: start in window W0, busy W1..W5, released W6.
    d_uses_md = 1'b1; md_start = 1'b1; md_is_div = 1'b0;
    @(negedge clk);
    check("mult.w0.md_busy", {31'd0, md_busy}, 32'd0);
    check_en("mult.w0", 1'b0);
    step();
    md_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("mult.w%0d.md_busy", i), {31'd0, md_busy}, 32'd1);
      check_en($sformatf("mult.w%0d", i), 1'b0);
      step();
    end
    @(negedge clk);
    check("mult.w6.md_busy", {31'd0, md_busy}, 32'd0);
    check_en("mult.w6", 1'b1);
`ifdef HAZARD_STALL_PERF_EN
    check("perf.md_stall_cycles", md_stall_cycles, 32'd6);
    check("perf.stall_cycles", stall_cycles, 32'd6);
`endif
    step();

    // Div: busy exactly 10 windows; a restart in busy window 3 must not extend it.
    md_start = 1'b1; md_is_div = 1'b1;
    @(negedge clk);
    check_en("div.w0", 1'b0);
    step();
    md_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      md_start = (i == 3);
      @(negedge clk);
      check($sformatf("div.w%0d.md_busy", i), {31'd0, md_busy}, 32'd1);
      step();
      md_start = 1'b0;
    end
    @(negedge clk);
    check("div.w11.md_busy", {31'd0, md_busy}, 32'd0);
    check_en("div.w11", 1'b1);
    step();

    // Reset in busy window 3 drops md_busy at once; then a fresh mult gets a full window.
    md_start = 1'b1; md_is_div = 1'b0;
    step();
    md_start = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst.w3.md_busy", {31'd0, md_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async.md_busy", {31'd0, md_busy}, 32'd0);
    check_en("rst.async", 1'b1);
    step();
    rst_n = 1'b1;
    step();
    md_start = 1'b1;
    @(negedge clk);
    check("rst.new.w0.md_busy", {31'd0, md_busy}, 32'd0);
    step();
    md_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("rst.new.w%0d.md_busy", i), {31'd0, md_busy}, 32'd1);
      step();
    end
    @(negedge clk);
    check("rst.new.w6.md_busy", {31'd0, md_busy}, 32'd0);
    check_en("rst.new.w6", 1'b1);
    step();
    clear_inputs();

    //       tag              rs    tuse  rt    tuse  e_dst e_tn  m_dst m_tn  en
    hz_vec("loaduse.e",      5'd8, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0);
    hz_vec("loaduse.clear",  5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 5'd8, 2'd1, 1'b1);
    hz_vec("zero.immune",    5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd2, 1'b1);
    hz_vec("rt.m.stall",     5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0);
    hz_vec("tuse3.nostall",  5'd7, 2'd3, 5'd7, 2'd3, 5'd7, 2'd2, 5'd7, 2'd2, 1'b1);
    hz_vec("tnew_eq_tuse",   5'd5, 2'd2, 5'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1);
    hz_vec("both.m_only",    5'd4, 2'd0, 5'd0, 2'd3, 5'd4, 2'd0, 5'd4, 2'd1, 1'b0);
    hz_vec("addr.differs",   5'd3, 2'd0, 5'd6, 2'd0, 5'd10, 2'd2, 5'd11, 2'd2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: the directed sequence is short, so any overrun means a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
